grn_gen: RTL and testbench
==========================

# grn_gen

Gaussian random number generator for the Black-Scholes datapath. It produces IEEE-754 single-precision samples, approximately N(0,1), that feed the `const2` multiplier input of the BS processor, replacing the constant −1.0 test value. Uniform bits come from a taus88 combined Tausworthe generator. Normality comes from the central limit theorem: the sum of twelve 16-bit uniforms, centred, is converted exactly to float.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge
- `nreset`  in  1  asynchronous, active-low reset
- `seed_load`  in  1  one-cycle pulse; reseeds the generator and flushes the pipeline
- `seed`  in  32  seed value, sampled when `seed_load`=1
- `run`  in  1  level; while 1, the generator advances one word per cycle
- `grn_valid`  out  1  one-cycle pulse; `grn_dout` holds a new sample
- `grn_dout`  out  32  IEEE-754 single-precision sample; held between pulses
- `sample_cnt`  out  32  samples emitted since reset or the last `seed_load`; wraps at 2^32

## Operation
- **State registers:** s1, s2, s3 (32 bits each).
- **Seeding:** s1=seed|0x2; s2=(seed^0x9E3779B9)|0x8; s3=(seed^0x7F4A7C15)|0x10.
  - Reset loads the seed=0 values.
  - These values guarantee the taus88 minimums (s1>1, s2>7, s3>15).
- **Step** (in the run cycle):
  - s1'=((s1&0xFFFFFFFE)<<12)^(((s1<<13)^s1)>>19)
  - s2'=((s2&0xFFFFFFF8)<<4)^(((s2<<2)^s2)>>25)
  - s3'=((s3&0xFFFFFFF0)<<17)^(((s3<<3)^s3)>>11)
  - Word register w<=s1'^s2'^s3'; w_valid<=1.
- **Accumulate:** each cycle with w_valid, acc += w[31:16]+w[15:0].
  - Phase counter counts 0..5.
  - acc is 20 bits unsigned; max 12·65535=786420.
- **Centre:** after the 6th add (phase 5→0):
  - c <= acc_final − 393210, 21-bit signed, range ±393210.
  - acc clears to 0 in the same cycle; c_valid<=1.
- **Convert:** value = c/2^16; the conversion is exact, with no rounding.
  - sign=c[20]; m=|c| (at most 19 significant bits).
  - p = index of the leading one; exponent=111+p.
  - mantissa = m shifted left by (23−p), dropping the implicit bit.
  - c=0 gives 0x00000000. +0 only; −0 is never produced.
- **Output register:** grn_dout, grn_valid, and sample_cnt+1.
- **Stall:** run=0 freezes s1–s3, phase and acc, and drives w_valid to 0.
  - Samples already in c/output stages still drain.
  - Resuming continues the same sequence with no sample lost or duplicated.
- **Reseed:** `seed_load` has priority over `run` in the same cycle.
  - Loads the states and clears w_valid, acc, phase, c_valid, grn_valid and sample_cnt.
  - grn_dout keeps its last value.
  - Nothing in flight is ever emitted.

## Timing
- **Reset values:** grn_valid=0, grn_dout=0, sample_cnt=0; internal acc/phase/valids=0.
- **Edge numbering:** edge 0 is the first rising edge with run=1 after reset or seed_load.
  - Words are captured at edges 0..5 and added at edges 1..6.
  - c is registered at edge 7; grn_valid=1 after edge 8.
- **Throughput:** with run held at 1, one sample every 6 cycles. Latency from the first run edge to the first valid is 8 edges.
- **Stalls:** each cycle of run=0 while a sample is still accumulating delays that sample by exactly 1 cycle.
- **Reset mid-operation:** asynchronous; all outputs return to reset values immediately.

## Structure
- **Package grn_pkg:**
  - taus88 masks and shift amounts
  - seed XOR constants 0x9E3779B9 and 0x7F4A7C15
  - CLT_OFFSET=393210, WORDS_PER_SAMPLE=6, EXP_BIAS_ADJ=111
- **Sub-module grn_fix2fp:** 21-bit signed fixed point (Q4.16) to float, combinational. grn_gen registers its output.
- Top level holds the taus88 step, accumulator/phase FSM, centring and output registers.

## Test plan
- **Reset:** assert nreset=0 mid-run → grn_valid=0, grn_dout=0, sample_cnt=0 asynchronously; after release with run=1, first valid at edge 8.
- **Golden sequence:** seed_load with seed=0x00000001, run held at 1 for 6000 cycles → 1000 grn_valid pulses spaced exactly 6 cycles apart; every grn_dout bit-exact to a C taus88+CLT reference model; sample_cnt=1000.
- **Stall:** same seed, toggle run in a random pattern → output sequence identical to the golden sequence, only delayed; each delay equals the number of stalled accumulation cycles.
- **Reseed mid-sample:** pulse seed_load at phase 3 with run=1 → no pulse for the interrupted sample; sample_cnt=0; subsequent samples equal the golden sequence for the new seed.
- **grn_fix2fp unit test:**
  - 0→0x00000000
  - 65536→0x3F800000
  - −65536→0xBF800000
  - 1→0x37800000
  - −1→0xB7800000
  - 98304→0x3FC00000
- **Statistics:** 65536 samples from seed 0x12345678 → |mean|<0.02, variance in 0.97–1.03, all |x|≤5.9999.

Source files
------------

// File: rtl/grn_pkg.sv
// Shared constants and helpers for the Gaussian random number generator:
// taus88 parameters, seeding constants and CLT/float conversion constants.
package grn_pkg;

  localparam logic [31:0] TAUS_M1 = 32'hFFFF_FFFE;
  localparam logic [31:0] TAUS_M2 = 32'hFFFF_FFF8;
  localparam logic [31:0] TAUS_M3 = 32'hFFFF_FFF0;

  // Shift triples per component: (mask shift, feedback shift, right shift)
  localparam int unsigned S1_K = 12, S1_Q = 13, S1_S = 19;
  localparam int unsigned S2_K = 4,  S2_Q = 2,  S2_S = 25;
  localparam int unsigned S3_K = 17, S3_Q = 3,  S3_S = 11;

  localparam logic [31:0] SEED_X2  = 32'h9E37_79B9;
  localparam logic [31:0] SEED_X3  = 32'h7F4A_7C15;
  localparam logic [31:0] SEED_OR1 = 32'h0000_0002;
  localparam logic [31:0] SEED_OR2 = 32'h0000_0008;
  localparam logic [31:0] SEED_OR3 = 32'h0000_0010;

  localparam logic signed [20:0] CLT_OFFSET       = 21'sd393210;
  localparam int unsigned        WORDS_PER_SAMPLE = 6;
  localparam logic [7:0]         EXP_BIAS_ADJ     = 8'd111;

  function automatic logic [31:0] taus_step(input logic [31:0] s, input logic [31:0] mask,
                                            input int unsigned k, input int unsigned q,
                                            input int unsigned sh);
    return ((s & mask) << k) ^ (((s << q) ^ s) >> sh);
  endfunction

  // The OR-ed bits keep every component above its taus88 minimum for any seed
  function automatic logic [31:0] seed_s1(input logic [31:0] sd);
    return sd | SEED_OR1;
  endfunction

  function automatic logic [31:0] seed_s2(input logic [31:0] sd);
    return (sd ^ SEED_X2) | SEED_OR2;
  endfunction

  function automatic logic [31:0] seed_s3(input logic [31:0] sd);
    return (sd ^ SEED_X3) | SEED_OR3;
  endfunction

endpackage

// File: rtl/grn_fix2fp.sv
// Exact conversion of a signed Q4.16 value (|x| < 2^19 LSBs) to IEEE-754
// single precision. Combinational; the caller registers the result.
module grn_fix2fp
  import grn_pkg::*;
(
  input  logic signed [20:0] fix_in,
  output logic [31:0]        fp_out
);

  logic        sign;
  logic [19:0] mag;
  logic [4:0]  p;
  logic [7:0]  exp_f;
  logic [22:0] mant;

  always_comb begin
    sign  = fix_in[20];
    mag   = 20'(sign ? -fix_in : fix_in);
    p     = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (mag[i]) p = 5'(i);
    end
    exp_f = EXP_BIAS_ADJ + {3'b000, p};
    // Shifting within 23 bits drops the implicit leading one
    mant  = 23'({3'b000, mag} << (5'd23 - p));
    if (mag == 20'd0) fp_out = 32'h0000_0000;
    else              fp_out = {sign, exp_f, mant};
  end

endmodule

// File: rtl/grn_gen.sv
// taus88 uniform source, 12-halfword CLT accumulator, centring and float
// output stage producing approximately N(0,1) single-precision samples.
module grn_gen
  import grn_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        seed_load,
  input  logic [31:0] seed,
  input  logic        run,
  output logic        grn_valid,
  output logic [31:0] grn_dout,
  output logic [31:0] sample_cnt
);

  logic [31:0]        s1, s2, s3;
  logic [31:0]        s1_n, s2_n, s3_n;
  logic [31:0]        w;
  logic               w_valid;
  logic [19:0]        acc, acc_base, acc_sum;
  logic [2:0]         phase;
  logic               acc_full;
  logic signed [20:0] c;
  logic               c_valid;
  logic [31:0]        fp;

  assign s1_n = taus_step(s1, TAUS_M1, S1_K, S1_Q, S1_S);
  assign s2_n = taus_step(s2, TAUS_M2, S2_K, S2_Q, S2_S);
  assign s3_n = taus_step(s3, TAUS_M3, S3_K, S3_Q, S3_S);

  // The cycle that centres a finished sum also starts the next sum from zero
  assign acc_base = acc_full ? 20'd0 : acc;
  assign acc_sum  = acc_base + {4'h0, w[31:16]} + {4'h0, w[15:0]};

  grn_fix2fp u_fix2fp (
    .fix_in (c),
    .fp_out (fp)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1         <= seed_s1(32'h0);
      s2         <= seed_s2(32'h0);
      s3         <= seed_s3(32'h0);
      w          <= 32'h0;
      w_valid    <= 1'b0;
      acc        <= 20'd0;
      phase      <= 3'd0;
      acc_full   <= 1'b0;
      c          <= 21'sd0;
      c_valid    <= 1'b0;
      grn_valid  <= 1'b0;
      grn_dout   <= 32'h0;
      sample_cnt <= 32'h0;
    end else if (seed_load) begin
      s1         <= seed_s1(seed);
      s2         <= seed_s2(seed);
      s3         <= seed_s3(seed);
      w_valid    <= 1'b0;
      acc        <= 20'd0;
      phase      <= 3'd0;
      acc_full   <= 1'b0;
      c_valid    <= 1'b0;
      grn_valid  <= 1'b0;
      sample_cnt <= 32'h0;
    end else begin
      if (run) begin
        s1 <= s1_n;
        s2 <= s2_n;
        s3 <= s3_n;
        w  <= s1_n ^ s2_n ^ s3_n;
      end
      w_valid  <= run;

      // A word captured just before a stall is still added, so none is lost
      acc_full <= 1'b0;
      if (w_valid) begin
        acc <= acc_sum;
        if (phase == 3'(WORDS_PER_SAMPLE - 1)) begin
          phase    <= 3'd0;
          acc_full <= 1'b1;
        end else begin
          phase <= phase + 3'd1;
        end
      end else if (acc_full) begin
        acc <= 20'd0;
      end

      c_valid <= acc_full;
      if (acc_full) c <= $signed({1'b0, acc}) - CLT_OFFSET;

      grn_valid <= c_valid;
      if (c_valid) begin
        grn_dout   <= fp;
        sample_cnt <= sample_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_grn_gen.sv
// Bench for grn_gen: a taus88+CLT reference model pushes expected samples and
// their emission cycle; a negedge monitor pops and compares.
module tb_grn_gen;

  logic        clk = 1'b0;
  logic        nreset;
  logic        seed_load;
  logic [31:0] seed;
  logic        run;
  logic        grn_valid;
  logic [31:0] grn_dout;
  logic [31:0] sample_cnt;

  logic signed [20:0] ut_in;
  logic [31:0]        ut_out;

  grn_gen dut (
    .clk        (clk),
    .nreset     (nreset),
    .seed_load  (seed_load),
    .seed       (seed),
    .run        (run),
    .grn_valid  (grn_valid),
    .grn_dout   (grn_dout),
    .sample_cnt (sample_cnt)
  );

  grn_fix2fp u_ut (
    .fix_in (ut_in),
    .fp_out (ut_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          total = 0;
  int          bad = 0;
  int          exp_cnt = 0;
  logic [31:0] last_exp = 32'h0;

  logic [31:0] m1, m2, m3;
  int          m_acc, m_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent float encoding through the host double representation
  function automatic logic [31:0] f32_of(input int c);
    real         r;
    logic [63:0] d;
    int          e;
    if (c == 0) return 32'h0;
    r = real'(c) / 65536.0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  task automatic model_seed(input logic [31:0] sd);
    m1 = sd | 32'h2;
    m2 = (sd ^ 32'h9E3779B9) | 32'h8;
    m3 = (sd ^ 32'h7F4A7C15) | 32'h10;
    m_acc = 0;
    m_n = 0;
  endtask

  // One generator word; after six words the sample and its emission cycle
  // (capture edge + 3) are queued
  task automatic model_word();
    logic [31:0] b, w;
    int          c;
    b  = ((m1 << 13) ^ m1) >> 19;
    m1 = ((m1 & 32'hFFFFFFFE) << 12) ^ b;
    b  = ((m2 << 2) ^ m2) >> 25;
    m2 = ((m2 & 32'hFFFFFFF8) << 4) ^ b;
    b  = ((m3 << 3) ^ m3) >> 11;
    m3 = ((m3 & 32'hFFFFFFF0) << 17) ^ b;
    w  = m1 ^ m2 ^ m3;
    m_acc += int'(w[31:16]) + int'(w[15:0]);
    m_n++;
    if (m_n == 6) begin
      c = m_acc - 393210;
      last_exp = f32_of(c);
      exp_q.push_back(last_exp);
      exp_cyc_q.push_back(cyc + 4);
      m_acc = 0;
      m_n = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic r);
    run = r;
    if (r) model_word();
    @(posedge clk);
    #1;
  endtask

  task automatic reseed(input logic [31:0] sd);
    seed      = sd;
    seed_load = 1'b1;
    run       = 1'b1;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    run       = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_cnt = 0;
    model_seed(sd);
  endtask

  task automatic drain(input int n);
    repeat (n) tick(1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] ed;
    int          ec;
    if (nreset && grn_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got grn_dout %h with no sample expected (cycle %0d)",
                 grn_dout, cyc);
      end else begin
        ed = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        exp_cnt++;
        chk("grn_dout", grn_dout, ed);
        chk("valid_cycle", 32'(cyc), 32'(ec));
        chk("sample_cnt", sample_cnt, 32'(exp_cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  int          ut_v[8] = '{0, 65536, -65536, 1, -1, 98304, 393210, -393210};
  logic [31:0] ut_e[8] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h37800000,
                           32'hB7800000, 32'h3FC00000, 32'h40BFFF40, 32'hC0BFFF40};
  logic [31:0] dout_keep;

  initial begin
    nreset    = 1'b0;
    seed_load = 1'b0;
    seed      = 32'h0;
    run       = 1'b0;
    ut_in     = 21'sd0;
    model_seed(32'h0);

    #12;
    chk("reset_grn_valid", {31'h0, grn_valid}, 32'h0);
    chk("reset_grn_dout", grn_dout, 32'h0);
    chk("reset_sample_cnt", sample_cnt, 32'h0);
    @(posedge clk);
    #1;
    nreset = 1'b1;

    // fixed-point to float conversion vectors
    for (int i = 0; i < 8; i++) begin
      ut_in = 21'(ut_v[i]);
      #1;
      chk($sformatf("fix2fp_%0d", ut_v[i]), ut_out, ut_e[i]);
    end

    // golden sequence, run held high
    reseed(32'h00000001);
    repeat (6000) tick(1'b1);
    drain(5);
    chk("golden_sample_cnt", sample_cnt, 32'd1000);

    // same seed with random stalls
    reseed(32'h00000001);
    repeat (1200) tick(1'($urandom_range(0, 3) != 0));
    drain(5);

    // reseed while the third sample is accumulating
    reseed(32'hCAFEF00D);
    repeat (15) tick(1'b1);
    dout_keep = last_exp;
    reseed(32'h5A5A1234);
    chk("reseed_sample_cnt", sample_cnt, 32'h0);
    chk("reseed_grn_valid", {31'h0, grn_valid}, 32'h0);
    chk("reseed_dout_hold", grn_dout, dout_keep);
    repeat (60) tick(1'b1);
    drain(5);

    // asynchronous reset in the middle of a run
    repeat (20) tick(1'b1);
    nreset = 1'b0;
    #2;
    chk("async_rst_grn_valid", {31'h0, grn_valid}, 32'h0);
    chk("async_rst_grn_dout", grn_dout, 32'h0);
    chk("async_rst_sample_cnt", sample_cnt, 32'h0);
    exp_q.delete();
    exp_cyc_q.delete();
    exp_cnt = 0;
    model_seed(32'h0);
    run = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    repeat (30) tick(1'b1);
    drain(5);
    chk("post_rst_sample_cnt", sample_cnt, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
